// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary (optionally signed) to packed BCD converter
//   clk, rst  : clock, synchronous active-high reset
//   start_i   : request conversion, honoured only in IDLE
//   din_i     : sample, captured on the edge that accepts start_i
//   busy_o    : high while shifting (WIDTH cycles)
//   done_o    : one-cycle pulse when bcd_o/neg_o/ovf_o are updated
//   neg_o     : sign of last converted sample
//   ovf_o     : magnitude exceeded 10^DIGITS-1 on last conversion
//   bcd_o     : packed digits, [3:0] = ones; 4'hF = blank
module bin2bcd_seq #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4,
  parameter bit SIGNED = 1'b1,
  parameter bit BLANK  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [WIDTH-1:0]    din_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                neg_o,
  output logic                ovf_o,
  output logic [4*DIGITS-1:0] bcd_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [4*DIGITS-1:0] dig_q, dig_d, adj, dig_sh, fmt, bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wovf_q, wovf_d, wneg_q, wneg_d, neg_q, neg_d, ovf_q, ovf_d;
  logic                carry, ovf_fin, seen, neg_in;
  assign neg_in = SIGNED && din_i[WIDTH-1];
  assign busy_o = state_q == SHIFT;
  assign done_o = state_q == DONE;
  assign neg_o  = neg_q;
  assign ovf_o  = ovf_q;
  assign bcd_o  = bcd_q;
  // one double-dabble step plus the output formatting of its result
  always_comb begin
    adj = dig_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = dig_q[4*i+:4] >= 4'd5 ? dig_q[4*i+:4] + 4'd3 : dig_q[4*i+:4];
    {carry, dig_sh} = {adj, mag_q[WIDTH-1]};
    ovf_fin = wovf_q | carry;
    fmt = dig_sh;
    seen = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen = seen | (dig_sh[4*i+:4] != 4'd0);
      if (!seen && BLANK) fmt[4*i+:4] = 4'hF;
    end
    if (ovf_fin) fmt = '1;
  end
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    wovf_d  = wovf_q;
    wneg_d  = wneg_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = SHIFT;
        mag_d   = neg_in ? -din_i : din_i;
        wneg_d  = neg_in;
        dig_d   = '0;
        wovf_d  = 1'b0;
        cnt_d   = CW'(WIDTH);
      end
      SHIFT: begin
        mag_d  = {mag_q[WIDTH-2:0], 1'b0};
        dig_d  = dig_sh;
        wovf_d = ovf_fin;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = fmt;
          neg_d   = wneg_q;
          ovf_d   = ovf_fin;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      wovf_q  <= 1'b0;
      wneg_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      wovf_q  <= wovf_d;
      wneg_q  <= wneg_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench over four bin2bcd_seq configurations
module tb_bin2bcd_seq;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       start = '0;
  logic [3:0][11:0] din = '0;
  logic [3:0]       busy, done, neg, ovf;
  logic [3:0][15:0] bcd;
  int               checks = 0;
  int               errors = 0;
  typedef struct {int id; logic [15:0] b; logic n; logic o;} exp_t;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  // 0: unsigned 4 digits, 1: signed, 2: signed blanked, 3: unsigned 3 digits
  bin2bcd_seq #(.WIDTH(12), .DIGITS(4), .SIGNED(1'b0), .BLANK(1'b0)) u0 (
    .clk(clk), .rst(rst), .start_i(start[0]), .din_i(din[0]), .busy_o(busy[0]),
    .done_o(done[0]), .neg_o(neg[0]), .ovf_o(ovf[0]), .bcd_o(bcd[0]));
  bin2bcd_seq #(.WIDTH(12), .DIGITS(4), .SIGNED(1'b1), .BLANK(1'b0)) u1 (
    .clk(clk), .rst(rst), .start_i(start[1]), .din_i(din[1]), .busy_o(busy[1]),
    .done_o(done[1]), .neg_o(neg[1]), .ovf_o(ovf[1]), .bcd_o(bcd[1]));
  bin2bcd_seq #(.WIDTH(12), .DIGITS(4), .SIGNED(1'b1), .BLANK(1'b1)) u2 (
    .clk(clk), .rst(rst), .start_i(start[2]), .din_i(din[2]), .busy_o(busy[2]),
    .done_o(done[2]), .neg_o(neg[2]), .ovf_o(ovf[2]), .bcd_o(bcd[2]));
  bin2bcd_seq #(.WIDTH(12), .DIGITS(3), .SIGNED(1'b0), .BLANK(1'b0)) u3 (
    .clk(clk), .rst(rst), .start_i(start[3]), .din_i(din[3]), .busy_o(busy[3]),
    .done_o(done[3]), .neg_o(neg[3]), .ovf_o(ovf[3]), .bcd_o(bcd[3][11:0]));
  assign bcd[3][15:12] = 4'h0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (busy[i] && done[i]) begin
        errors++;
        $display("FAIL busy_done_overlap inst %0d: both high", i);
      end
      if (done[i]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_done inst %0d: bcd=%h with nothing expected", i, bcd[i]);
        end else begin
          e = q.pop_front();
          if (e.id != i || bcd[i] !== e.b || neg[i] !== e.n || ovf[i] !== e.o) begin
            errors++;
            $display("FAIL result inst %0d: got bcd=%h neg=%b ovf=%b, want inst %0d bcd=%h neg=%b ovf=%b",
                     i, bcd[i], neg[i], ovf[i], e.id, e.b, e.n, e.o);
          end
        end
      end
    end
  end
  task automatic go(input int id, input logic [11:0] d, input logic [15:0] b, input logic n, input logic o);
    q.push_back('{id, b, n, o});
    start[id] = 1'b1;
    din[id] = d;
    @(posedge clk);
    #1;
    start[id] = 1'b0;
    din[id] = '0;
  endtask
  task automatic wait_done(input int id, input int lat);
    int k;
    int nb;
    nb = busy[id] ? 1 : 0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done[id]) break;
      nb += busy[id] ? 1 : 0;
    end
    checks++;
    if (k != lat || nb != lat) begin
      errors++;
      $display("FAIL latency inst %0d: done after %0d edges busy %0d cycles, want %0d and %0d", id, k, nb, lat, lat);
    end
  endtask
  task automatic conv(input int id, input logic [11:0] d, input logic [15:0] b, input logic n, input logic o);
    go(id, d, b, n, o);
    wait_done(id, 12);
    @(posedge clk);
    #1;
  endtask
  initial begin
    start = '1;
    repeat (3) @(posedge clk);
    #1;
    start = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy[i], done[i], neg[i], ovf[i]} !== 4'b0 || bcd[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_state inst %0d: busy=%b done=%b neg=%b ovf=%b bcd=%h, want all 0",
                 i, busy[i], done[i], neg[i], ovf[i], bcd[i]);
      end
    end
    conv(0, 12'd1234, 16'h1234, 1'b0, 1'b0);
    conv(0, 12'd4095, 16'h4095, 1'b0, 1'b0);
    conv(1, 12'hFFF, 16'h0001, 1'b1, 1'b0);
    conv(1, 12'h800, 16'h2048, 1'b1, 1'b0);
    conv(1, 12'h7FF, 16'h2047, 1'b0, 1'b0);
    conv(2, 12'hFFF, 16'hFFF1, 1'b1, 1'b0);
    conv(2, 12'h000, 16'hFFF0, 1'b0, 1'b0);
    conv(2, 12'd105, 16'hF105, 1'b0, 1'b0);
    conv(2, 12'hFCE, 16'hFF50, 1'b1, 1'b0);
    conv(3, 12'd999, 16'h0999, 1'b0, 1'b0);
    conv(3, 12'd1000, 16'h0FFF, 1'b0, 1'b1);
    conv(3, 12'd4095, 16'h0FFF, 1'b0, 1'b1);
    go(0, 12'd500, 16'h0500, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start[0] = 1'b1;
    din[0] = 12'd7;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_done(0, 9);
    q.push_back('{0, 16'h0007, 1'b0, 1'b0});
    start[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start[0] = 1'b0;
    din[0] = '0;
    wait_done(0, 12);
    @(posedge clk);
    #1;
    start[0] = 1'b1;
    din[0] = 12'd321;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || bcd[0] !== 16'h0 || neg[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b bcd=%h neg=%b ovf=%b, want 0 0000 0 0", busy[0], bcd[0], neg[0], ovf[0]);
    end
    repeat (20) @(posedge clk);
    #1;
    conv(0, 12'd321, 16'h0321, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_done: %0d results never produced, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
